// File: rtl/apb_cmd_queue_if.sv
// Bundled command, response, APB-master drive and bus-monitor signals of the APB command queue.
// The queue itself uses the slave modport; its environment uses the master modport.
interface apb_cmd_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_W-1:0]         cmd_addr;
    logic [DATA_W-1:0]         cmd_wdata;
    logic [DATA_W/8-1:0]       cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      transfer;
    logic                      SWRITE;
    logic [ADDR_W-1:0]         SADDR;
    logic [DATA_W-1:0]         SWDATA;
    logic [DATA_W/8-1:0]       SSTRB;
    logic [2:0]                SPROT;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PREADY;
    logic                      PSLVERR;
    logic [DATA_W-1:0]         PRDATA;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_write;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic [$clog2(DEPTH):0]    cmd_count;
    logic [7:0]                err_count;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA, rsp_ready,
        output cmd_ready, transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err, cmd_count, err_count
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output PSEL, PENABLE, PREADY, PSLVERR, PRDATA, rsp_ready,
        input  cmd_ready, transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err, cmd_count, err_count
    );
endinterface

// File: rtl/apb_cmd_queue.sv
// Command FIFO in front of an APB master: issues one queued command at a time, watches the
// shared bus for the completing access and holds exactly one response until it is consumed.
module apb_cmd_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_cmd_queue_if.slave bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W + 3;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 transfer_s;

    logic [ENTRY_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 done_s;

    logic                 head_write_s;
    logic [ADDR_W-1:0]    head_addr_s;
    logic [DATA_W-1:0]    head_wdata_s;
    logic [STRB_W-1:0]    head_strb_s;
    logic [2:0]           head_prot_s;

    logic                 swrite_r;
    logic [ADDR_W-1:0]    saddr_r;
    logic [DATA_W-1:0]    swdata_r;
    logic [STRB_W-1:0]    sstrb_r;
    logic [2:0]           sprot_r;

    logic                 rsp_valid_r;
    logic                 rsp_write_r;
    logic [DATA_W-1:0]    rsp_rdata_r;
    logic                 rsp_err_r;
    logic [7:0]           err_count_r;

    // No pass-through at full: cmd_ready depends only on the registered count.
    assign push_s = bus.cmd_valid && (count_r != FULL_C);
    assign pop_s  = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}}) && !rsp_valid_r;
    assign done_s = (state_r == ST_WAIT) && bus.PSEL && bus.PENABLE && bus.PREADY;

    assign {head_write_s, head_addr_s, head_wdata_s, head_strb_s, head_prot_s} = mem_r[rd_ptr_r];

    // Command storage; payload needs no reset because occupancy gates every read.
    always_ff @(posedge PCLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata,
                                bus.cmd_strb, bus.cmd_prot};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue FSM next state; transfer is asserted only while waiting for the master to select.
    always_comb begin
        state_nxt_s = state_r;
        transfer_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                transfer_s = 1'b1;
                if (bus.PSEL) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Hold registers for the master; they change only when a new command is popped.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            swrite_r <= 1'b0;
            saddr_r  <= {ADDR_W{1'b0}};
            swdata_r <= {DATA_W{1'b0}};
            sstrb_r  <= {STRB_W{1'b0}};
            sprot_r  <= 3'b000;
        end else if (pop_s) begin
            swrite_r <= head_write_s;
            saddr_r  <= head_addr_s;
            swdata_r <= head_wdata_s;
            sstrb_r  <= head_write_s ? head_strb_s : {STRB_W{1'b0}};
            sprot_r  <= head_prot_s;
        end
    end

    // Single response slot, filled by the completing access and freed by the handshake.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (done_s) begin
            rsp_valid_r <= 1'b1;
            rsp_write_r <= swrite_r;
            rsp_rdata_r <= swrite_r ? {DATA_W{1'b0}} : bus.PRDATA;
            rsp_err_r   <= bus.PSLVERR;
        end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Saturating count of completions that reported a slave error.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_count_r <= 8'd0;
        end else if (done_s && bus.PSLVERR && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end
    end

    assign bus.cmd_ready = (count_r != FULL_C);
    assign bus.cmd_count = count_r;
    assign bus.transfer  = transfer_s;
    assign bus.SWRITE    = swrite_r;
    assign bus.SADDR     = saddr_r;
    assign bus.SWDATA    = swdata_r;
    assign bus.SSTRB     = sstrb_r;
    assign bus.SPROT     = sprot_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_write = rsp_write_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: the bench plays the APB master/slave pair on the monitor
// inputs, keeps a small slave memory and checks every response against hand-computed values.
module tb_apb_cmd_queue;
    logic PCLK;
    logic PRESET;
    int   n_total;
    int   n_passed;
    int   rsp_count;
    logic [31:0] tb_mem [64];

    apb_cmd_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus ();

    apb_cmd_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Response handshakes seen on the bus.
    always @(posedge PCLK) begin
        if (!PRESET && bus.rsp_valid && bus.rsp_ready) rsp_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check_eq("push_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
    endtask

    // Plays one APB access for the issued command; slave errors above 0xFF.
    task automatic apb_serve(input logic exp_w, input logic [31:0] exp_a, input logic [31:0] exp_d,
                             input logic [3:0] exp_s, input logic [2:0] exp_p, input int waits);
        int n;
        logic err;
        logic w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        n = 0;
        while (bus.transfer !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        check_eq("xfer_start", 32'(bus.transfer), 32'd1);
        check_eq("swrite", 32'(bus.SWRITE), 32'(exp_w));
        check_eq("saddr", bus.SADDR, exp_a);
        check_eq("swdata", bus.SWDATA, exp_d);
        check_eq("sstrb", 32'(bus.SSTRB), 32'(exp_s));
        check_eq("sprot", 32'(bus.SPROT), 32'(exp_p));
        w = bus.SWRITE;
        a = bus.SADDR;
        d = bus.SWDATA;
        s = bus.SSTRB;
        err = (a >= 32'h0000_0100);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        @(negedge PCLK);
        check_eq("xfer_drop", 32'(bus.transfer), 32'd0);
        bus.PENABLE = 1'b1;
        bus.PSLVERR = err;
        bus.PRDATA  = w ? 32'hA5A5_A5A5 : (err ? 32'h0BAD_0BAD : tb_mem[a[7:2]]);
        bus.PREADY  = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            @(negedge PCLK);
            check_eq("wait_saddr", bus.SADDR, a);
            check_eq("wait_swdata", bus.SWDATA, d);
            check_eq("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
            if (i == waits - 1) bus.PREADY = 1'b1;
        end
        @(negedge PCLK);
        if (w && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) tb_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
    endtask

    task automatic expect_rsp(input logic exp_w, input logic [31:0] exp_rd, input logic exp_err);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("rsp_write", 32'(bus.rsp_write), 32'(exp_w));
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        check_eq("rsp_clear", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n0;
        n_total = 0;
        n_passed = 0;
        rsp_count = 0;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'd0;
        PRESET = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_wdata = 32'd0;
        bus.cmd_strb  = 4'd0;
        bus.cmd_prot  = 3'd0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge PCLK);

        // Reset state
        check_eq("rst_count", 32'(bus.cmd_count), 32'd0);
        check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_xfer", 32'(bus.transfer), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_saddr", bus.SADDR, 32'd0);
        check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Single write
        push_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0);
        apb_serve(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 0);
        expect_rsp(1'b1, 32'd0, 1'b0);

        // Write then read-back, back-to-back commands
        push_cmd(1'b1, 32'h14, 32'h1234_5678, 4'hF, 3'd1);
        push_cmd(1'b0, 32'h10, 32'h0, 4'hF, 3'd2);
        apb_serve(1'b1, 32'h14, 32'h1234_5678, 4'hF, 3'd1, 0);
        expect_rsp(1'b1, 32'd0, 1'b0);
        apb_serve(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0);
        expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);

        // Fill: five pushes, one popped, FIFO full with the response held
        push_cmd(1'b1, 32'h20, 32'h1111_1111, 4'hF, 3'd0);
        push_cmd(1'b1, 32'h24, 32'h1122_3344, 4'h3, 3'd0);
        push_cmd(1'b1, 32'h28, 32'h3333_3333, 4'hF, 3'b101);
        push_cmd(1'b1, 32'h2C, 32'h4444_4444, 4'hF, 3'd0);
        push_cmd(1'b0, 32'h24, 32'h0, 4'hF, 3'd0);
        check_eq("full_count", 32'(bus.cmd_count), 32'd4);
        check_eq("full_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h30;
        repeat (3) @(negedge PCLK);
        check_eq("stall_count", 32'(bus.cmd_count), 32'd4);
        bus.cmd_valid = 1'b0;
        apb_serve(1'b1, 32'h20, 32'h1111_1111, 4'hF, 3'd0, 0);
        repeat (4) @(negedge PCLK);
        check_eq("held_no_xfer", 32'(bus.transfer), 32'd0);
        check_eq("held_count", 32'(bus.cmd_count), 32'd4);
        expect_rsp(1'b1, 32'd0, 1'b0);
        apb_serve(1'b1, 32'h24, 32'h1122_3344, 4'h3, 3'd0, 0);
        expect_rsp(1'b1, 32'd0, 1'b0);
        apb_serve(1'b1, 32'h28, 32'h3333_3333, 4'hF, 3'b101, 0);
        expect_rsp(1'b1, 32'd0, 1'b0);
        apb_serve(1'b1, 32'h2C, 32'h4444_4444, 4'hF, 3'd0, 0);
        expect_rsp(1'b1, 32'd0, 1'b0);
        apb_serve(1'b0, 32'h24, 32'h0, 4'h0, 3'd0, 0);
        expect_rsp(1'b0, 32'h0000_3344, 1'b0);
        check_eq("drain_count", 32'(bus.cmd_count), 32'd0);

        // Slave errors and saturation
        push_cmd(1'b1, 32'h200, 32'h5555_5555, 4'hF, 3'd0);
        apb_serve(1'b1, 32'h200, 32'h5555_5555, 4'hF, 3'd0, 0);
        expect_rsp(1'b1, 32'd0, 1'b1);
        check_eq("err_count_1", 32'(bus.err_count), 32'd1);
        push_cmd(1'b0, 32'h300, 32'h0, 4'h0, 3'd0);
        apb_serve(1'b0, 32'h300, 32'h0, 4'h0, 3'd0, 0);
        expect_rsp(1'b0, 32'h0BAD_0BAD, 1'b1);
        check_eq("err_count_2", 32'(bus.err_count), 32'd2);
        for (int i = 0; i < 253; i++) begin
            push_cmd(1'b1, 32'h200, 32'(i), 4'hF, 3'd0);
            apb_serve(1'b1, 32'h200, 32'(i), 4'hF, 3'd0, 0);
            expect_rsp(1'b1, 32'd0, 1'b1);
        end
        check_eq("err_count_255", 32'(bus.err_count), 32'd255);
        push_cmd(1'b1, 32'h200, 32'h0, 4'hF, 3'd0);
        apb_serve(1'b1, 32'h200, 32'h0, 4'hF, 3'd0, 0);
        expect_rsp(1'b1, 32'd0, 1'b1);
        check_eq("err_count_sat", 32'(bus.err_count), 32'd255);

        // Wait states
        n0 = rsp_count;
        push_cmd(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 3'b010);
        apb_serve(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 3'b010, 3);
        expect_rsp(1'b1, 32'd0, 1'b0);
        repeat (3) @(negedge PCLK);
        check_eq("wait_one_rsp", 32'(rsp_count), 32'(n0 + 1));
        push_cmd(1'b0, 32'h30, 32'h0, 4'hF, 3'd0);
        apb_serve(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 1);
        expect_rsp(1'b0, 32'hCAFE_F00D, 1'b0);

        // Reset while in WAIT with two commands queued
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
        push_cmd(1'b1, 32'h14, 32'h7777_7777, 4'hF, 3'd0);
        push_cmd(1'b1, 32'h18, 32'h8888_8888, 4'hF, 3'd0);
        check_eq("pre_rst_xfer", 32'(bus.transfer), 32'd1);
        bus.PSEL = 1'b1;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        bus.PREADY  = 1'b0;
        @(negedge PCLK);
        check_eq("pre_rst_count", 32'(bus.cmd_count), 32'd2);
        n0 = rsp_count;
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        check_eq("mid_rst_count", 32'(bus.cmd_count), 32'd0);
        check_eq("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check_eq("mid_rst_xfer", 32'(bus.transfer), 32'd0);
        check_eq("mid_rst_saddr", bus.SADDR, 32'd0);
        check_eq("mid_rst_err_count", 32'(bus.err_count), 32'd0);
        repeat (10) @(negedge PCLK);
        check_eq("post_rst_no_rsp", 32'(rsp_count), 32'(n0));
        check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("post_rst_xfer", 32'(bus.transfer), 32'd0);

        // Queue operates again after reset
        push_cmd(1'b0, 32'h14, 32'h0, 4'hF, 3'd0);
        apb_serve(1'b0, 32'h14, 32'h0, 4'h0, 3'd0, 0);
        expect_rsp(1'b0, 32'h1234_5678, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
